// File: rtl/memory_arbiter.sv
// Two-port valid/ready arbiter that sequences accesses to a single-port memory as setup, strobe, release.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default build is round-robin.
module memory_arbiter #(
    parameter  int WORD_SIZE = 4,
    parameter  int NUM_WORDS = 64,
    parameter  int READ_WAIT = 1,
    localparam int ADDR_W    = $clog2(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0Valid,
    output logic                 req0Ready,
    input  logic                 req0Write,
    input  logic [ADDR_W-1:0]    req0Addr,
    input  logic [WORD_SIZE-1:0] req0WData,
    output logic                 rsp0Valid,
    output logic [WORD_SIZE-1:0] rsp0RData,
    input  logic                 req1Valid,
    output logic                 req1Ready,
    input  logic                 req1Write,
    input  logic [ADDR_W-1:0]    req1Addr,
    input  logic [WORD_SIZE-1:0] req1WData,
    output logic                 rsp1Valid,
    output logic [WORD_SIZE-1:0] rsp1RData,
    output logic                 memEnable,
    output logic                 memReadWrite,
    output logic [ADDR_W-1:0]    memAddress,
    output logic [WORD_SIZE-1:0] memDataIn,
    input  logic [WORD_SIZE-1:0] memDataOut,
    output logic                 busy
);

    if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
        $error("memory_arbiter: READ_WAIT must be within 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_reg;
    logic        last_grant_reg;
    logic        port_reg;
    logic        write_reg;
    logic [3:0]  wait_cnt_reg;

    logic                 idle;
    logic                 prefer0;
    logic                 hs0;
    logic                 hs1;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;

    assign idle = (state_reg == IDLE);

`ifdef ARB_FIXED_PRIO_EN
    // lastGrant keeps being tracked so the build can switch policy without other changes
    assign prefer0 = last_grant_reg | 1'b1;
`else
    assign prefer0 = last_grant_reg;
`endif

    assign req0Ready = idle && req0Valid && (!req1Valid || prefer0);
    assign req1Ready = idle && req1Valid && (!req0Valid || !prefer0);

    assign hs0 = req0Valid && req0Ready;
    assign hs1 = req1Valid && req1Ready;

    assign sel_write = hs1 ? req1Write : req0Write;
    assign sel_addr  = hs1 ? req1Addr  : req0Addr;
    assign sel_wdata = hs1 ? req1WData : req0WData;

    // Address/data/direction are loaded at the handshake so they are already stable during SETUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            port_reg       <= 1'b0;
            write_reg      <= 1'b0;
            wait_cnt_reg   <= 4'd0;
            memEnable      <= 1'b0;
            memReadWrite   <= 1'b1;
            memAddress     <= '0;
            memDataIn      <= '0;
            rsp0Valid      <= 1'b0;
            rsp1Valid      <= 1'b0;
            rsp0RData      <= '0;
            rsp1RData      <= '0;
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hs0 || hs1) begin
                        port_reg       <= hs1;
                        last_grant_reg <= hs1;
                        write_reg      <= sel_write;
                        memAddress     <= sel_addr;
                        memDataIn      <= sel_wdata;
                        memReadWrite   <= ~sel_write;
                        busy           <= 1'b1;
                        state_reg      <= SETUP;
                    end
                end
                SETUP: begin
                    memEnable    <= 1'b1;
                    wait_cnt_reg <= 4'(READ_WAIT - 1);
                    state_reg    <= STROBE;
                end
                STROBE: begin
                    if (wait_cnt_reg != 4'd0) begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end else begin
                        memEnable    <= 1'b0;
                        memReadWrite <= 1'b1;
                        rsp0Valid    <= !port_reg;
                        rsp1Valid    <= port_reg;
                        if (!write_reg) begin
                            if (port_reg) begin
                                rsp1RData <= memDataOut;
                            end else begin
                                rsp0RData <= memDataOut;
                            end
                        end
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    rsp0Valid <= 1'b0;
                    rsp1Valid <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
